main_dec: RTL and testbench
===========================

MAIN_DEC -- requirements
Module: main_dec

Interface
REQ-001 The block SHALL have port `clk`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The block SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port `Op`, input, 6 bits: instruction opcode field [31:26].
REQ-004 The block SHALL have port `Stall`, input, 1 bit: when high, hold all registered outputs.
REQ-005 The block SHALL have port `Flush`, input, 1 bit: when high, load the bubble (all-zero) control word.
REQ-006 The block SHALL have outputs `MemtoReg`, `MemWrite`, `Branch`, `ALUSrc`, `RegDst`, `RegWrite`, `Jump`, each 1 bit: registered control signals.
REQ-007 The block SHALL have output `ALUOp`, 2 bits: registered ALU-decoder class (00 add, 01 subtract, 10 use funct field).
REQ-008 The block SHALL have output `Illegal`, 1 bit: registered flag, high when `Op` is an unsupported opcode.

Function
REQ-009 The block SHALL decode `Op` combinationally into a 10-bit control word {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, ALUOp[1:0], Jump, Illegal}.
REQ-010 R-type (000000) SHALL decode to RegWrite=1, RegDst=1, ALUSrc=0, Branch=0, MemWrite=0, MemtoReg=0, ALUOp=10, Jump=0.
REQ-011 lw (100011) SHALL decode to RegWrite=1, RegDst=0, ALUSrc=1, Branch=0, MemWrite=0, MemtoReg=1, ALUOp=00, Jump=0.
REQ-012 sw (101011) SHALL decode to RegWrite=0, RegDst=0, ALUSrc=1, Branch=0, MemWrite=1, MemtoReg=0, ALUOp=00, Jump=0.
REQ-013 beq (000100) SHALL decode to RegWrite=0, RegDst=0, ALUSrc=0, Branch=1, MemWrite=0, MemtoReg=0, ALUOp=01, Jump=0.
REQ-014 addi (001000) SHALL decode to RegWrite=1, RegDst=0, ALUSrc=1, Branch=0, MemWrite=0, MemtoReg=0, ALUOp=00, Jump=0.
REQ-015 j (000010) SHALL decode to Jump=1 with all other signals 0 and ALUOp=00.
REQ-016 Don't-care fields SHALL be driven 0; no X SHALL ever appear on any output.
REQ-017 Any other opcode SHALL decode to the all-zero control word with Illegal=1.
REQ-018 Outputs SHALL be registered: the decode of `Op` sampled at edge N SHALL appear after edge N, giving 1-cycle latency.
REQ-019 Register-load priority SHALL be reset > Flush > Stall > normal load.
REQ-020 Flush SHALL load the all-zero word with Illegal=0, even when Stall is also high.
REQ-021 Stall without Flush SHALL hold every output unchanged, regardless of `Op`.

Reset
REQ-022 On `reset` high at a rising edge, all outputs SHALL become 0, including ALUOp=00, Jump=0 and Illegal=0.
REQ-023 Reset SHALL override Stall and Flush.
REQ-024 Outputs SHALL reflect the new `Op` on the first edge after `reset` deasserts.

Structure
REQ-025 Opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J) and the ALUOp encodings SHALL reside in a shared package `mips_pkg`.
REQ-026 The combinational decode SHALL be one sub-module `main_dec_comb` (Op in, control word out); `main_dec` SHALL add the control register and Stall/Flush logic.

Verification
REQ-027 Reset scenario: reset=1 for 2 cycles with Op=100011 SHALL leave all outputs 0.
REQ-028 Opcode sweep: Op sequence 000000, 100011, 101011, 000100, 000010, one per cycle, SHALL produce the REQ-010/011/012/013/015 words, each one cycle later.
REQ-029 Addi and illegal: Op=001000 SHALL give RegWrite=1, ALUSrc=1, ALUOp=00; Op=111111 SHALL give the all-zero word with Illegal=1.
REQ-030 Stall: load lw, then Stall=1 with Op=101011 for 3 cycles SHALL hold MemtoReg=1 and MemWrite=0.
REQ-031 Flush: Flush=1 and Stall=1 with Op=000000 SHALL give all outputs 0 on the next cycle.
REQ-032 Exhaustive sweep: all 64 opcodes SHALL produce Illegal=1 for exactly 58 of them and never produce X.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode constants, ALU class encodings
// and the packed control word carried from the decoder to the register.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU-decoder class handed to the downstream ALU decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    // Field order matches the flat word
    // {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, ALUOp, Jump, Illegal}.
    typedef struct packed {
        logic    reg_write;
        logic    reg_dst;
        logic    alu_src;
        logic    branch;
        logic    mem_write;
        logic    mem_to_reg;
        alu_op_t alu_op;
        logic    jump;
        logic    illegal;
    } ctrl_word_t;

    // Pipeline bubble: nothing written, nothing branched, not flagged illegal.
    localparam ctrl_word_t CTRL_BUBBLE = '{
        reg_write:  1'b0,
        reg_dst:    1'b0,
        alu_src:    1'b0,
        branch:     1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        alu_op:     ALUOP_ADD,
        jump:       1'b0,
        illegal:    1'b0
    };

endpackage

// File: rtl/main_dec_comb.sv
// Purely combinational main decoder: opcode in, control word out.
// Unused fields are forced to 0 so no X can leak into the pipeline.
module main_dec_comb
    import mips_pkg::*;
(
    input  logic [5:0] op,
    output ctrl_word_t ctrl
);

    // Start from the bubble word and set only the fields each opcode needs.
    always_comb begin
        ctrl = CTRL_BUBBLE;
        case (op)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_SUB;
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            default: begin
                // Unsupported opcode: behave as a bubble but raise the flag.
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/main_dec.sv
// Registered main decoder: decodes Op one cycle ahead and holds the control
// word in a register with reset > Flush > Stall > load priority.
module main_dec
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       Stall,
    input  logic       Flush,
    output logic       MemtoReg,
    output logic       MemWrite,
    output logic       Branch,
    output logic       ALUSrc,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       Jump,
    output logic [1:0] ALUOp,
    output logic       Illegal
);

    ctrl_word_t ctrl_next;
    ctrl_word_t ctrl_reg;

    main_dec_comb u_comb (
        .op   (Op),
        .ctrl (ctrl_next)
    );

    // Control register: Flush wins over Stall so a squashed slot never keeps
    // a stale instruction; Stall simply freezes the word.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_reg <= CTRL_BUBBLE;
        end else if (Flush) begin
            ctrl_reg <= CTRL_BUBBLE;
        end else if (!Stall) begin
            ctrl_reg <= ctrl_next;
        end
    end

    // Break the registered word out onto the individual control ports.
    always_comb begin
        RegWrite = ctrl_reg.reg_write;
        RegDst   = ctrl_reg.reg_dst;
        ALUSrc   = ctrl_reg.alu_src;
        Branch   = ctrl_reg.branch;
        MemWrite = ctrl_reg.mem_write;
        MemtoReg = ctrl_reg.mem_to_reg;
        ALUOp    = ctrl_reg.alu_op;
        Jump     = ctrl_reg.jump;
        Illegal  = ctrl_reg.illegal;
    end

endmodule

// File: tb/tb_main_dec.sv
// Directed self-checking bench for main_dec. Inputs change 1 ns after each
// rising edge; outputs are sampled at that same point.
module tb_main_dec;

    logic       clk;
    logic       reset;
    logic [5:0] Op;
    logic       Stall;
    logic       Flush;
    logic       MemtoReg, MemWrite, Branch, ALUSrc, RegDst, RegWrite, Jump, Illegal;
    logic [1:0] ALUOp;

    int errors = 0;
    int checks = 0;

    // Word order {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, ALUOp[1:0], Jump, Illegal}
    localparam logic [9:0] W_ZERO = 10'b00_0000_00_00;
    localparam logic [9:0] W_R    = 10'b11_0000_10_00;
    localparam logic [9:0] W_LW   = 10'b10_1001_00_00;
    localparam logic [9:0] W_SW   = 10'b00_1010_00_00;
    localparam logic [9:0] W_BEQ  = 10'b00_0100_01_00;
    localparam logic [9:0] W_ADDI = 10'b10_1000_00_00;
    localparam logic [9:0] W_J    = 10'b00_0000_00_10;
    localparam logic [9:0] W_ILL  = 10'b00_0000_00_01;

    logic [9:0] obs;
    assign obs = {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, ALUOp, Jump, Illegal};

    main_dec dut (
        .clk      (clk),
        .reset    (reset),
        .Op       (Op),
        .Stall    (Stall),
        .Flush    (Flush),
        .MemtoReg (MemtoReg),
        .MemWrite (MemWrite),
        .Branch   (Branch),
        .ALUSrc   (ALUSrc),
        .RegDst   (RegDst),
        .RegWrite (RegWrite),
        .Jump     (Jump),
        .ALUOp    (ALUOp),
        .Illegal  (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-written expectation table for the exhaustive sweep.
    function automatic logic [9:0] expected_word(input logic [5:0] op);
        case (op)
            6'b000000: return W_R;
            6'b100011: return W_LW;
            6'b101011: return W_SW;
            6'b000100: return W_BEQ;
            6'b001000: return W_ADDI;
            6'b000010: return W_J;
            default:   return W_ILL;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1; Stall = 1'b0; Flush = 1'b0; Op = 6'b100011;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs !== W_ZERO) begin
                errors++;
                $display("FAIL reset_cycle%0d: got %b expected %b", i, obs, W_ZERO);
            end
            $display("reset cycle %0d op=%b word=%b", i, Op, obs);
        end
        // First edge after release must already carry the new decode.
        reset = 1'b0; Op = 6'b000100;
        step();
        checks++;
        if (obs !== W_BEQ) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", obs, W_BEQ);
        end
        $display("reset release op=%b word=%b", Op, obs);
    endtask

    task automatic test_sweep();
        logic [5:0] ops  [5] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
        logic [9:0] exps [5] = '{W_R, W_LW, W_SW, W_BEQ, W_J};
        for (int i = 0; i < 5; i++) begin
            Op = ops[i];
            step();
            checks++;
            if (obs !== exps[i]) begin
                errors++;
                $display("FAIL sweep_op%b: got %b expected %b", ops[i], obs, exps[i]);
            end
            $display("sweep op=%b word=%b", ops[i], obs);
        end
    endtask

    task automatic test_latency();
        // Change Op between edges: output must still show the previous decode.
        Op = 6'b001000;
        step();
        Op = 6'b101011;
        #2;
        checks++;
        if (obs !== W_ADDI) begin
            errors++;
            $display("FAIL latency_hold: got %b expected %b", obs, W_ADDI);
        end
        step();
        checks++;
        if (obs !== W_SW) begin
            errors++;
            $display("FAIL latency_next: got %b expected %b", obs, W_SW);
        end
        $display("latency op=%b word=%b", Op, obs);
    endtask

    task automatic test_addi_illegal();
        Op = 6'b001000;
        step();
        checks++;
        if (obs !== W_ADDI) begin
            errors++;
            $display("FAIL addi: got %b expected %b", obs, W_ADDI);
        end
        $display("addi op=%b word=%b", Op, obs);
        Op = 6'b111111;
        step();
        checks++;
        if (obs !== W_ILL) begin
            errors++;
            $display("FAIL illegal: got %b expected %b", obs, W_ILL);
        end
        $display("illegal op=%b word=%b", Op, obs);
    endtask

    task automatic test_stall();
        Op = 6'b100011;
        step();
        checks++;
        if (obs !== W_LW) begin
            errors++;
            $display("FAIL stall_load: got %b expected %b", obs, W_LW);
        end
        Stall = 1'b1; Op = 6'b101011;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== W_LW || MemtoReg !== 1'b1 || MemWrite !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: got %b expected %b", i, obs, W_LW);
            end
            $display("stall cycle %0d op=%b word=%b", i, Op, obs);
        end
        Stall = 1'b0;
        step();
        checks++;
        if (obs !== W_SW) begin
            errors++;
            $display("FAIL stall_release: got %b expected %b", obs, W_SW);
        end
        $display("stall release op=%b word=%b", Op, obs);
    endtask

    task automatic test_flush();
        Op = 6'b000000;
        step();
        Flush = 1'b1; Stall = 1'b1;
        step();
        checks++;
        if (obs !== W_ZERO) begin
            errors++;
            $display("FAIL flush_with_stall: got %b expected %b", obs, W_ZERO);
        end
        $display("flush+stall op=%b word=%b", Op, obs);
        // Flush alone on an illegal opcode: bubble must not carry Illegal.
        Stall = 1'b0; Op = 6'b111111;
        step();
        checks++;
        if (obs !== W_ZERO) begin
            errors++;
            $display("FAIL flush_illegal_op: got %b expected %b", obs, W_ZERO);
        end
        $display("flush op=%b word=%b", Op, obs);
        Flush = 1'b0; Op = 6'b000010;
        step();
        checks++;
        if (obs !== W_J) begin
            errors++;
            $display("FAIL flush_release: got %b expected %b", obs, W_J);
        end
    endtask

    task automatic test_reset_override();
        Op = 6'b000000;
        step();
        reset = 1'b1; Stall = 1'b1; Flush = 1'b1;
        step();
        checks++;
        if (obs !== W_ZERO) begin
            errors++;
            $display("FAIL reset_override: got %b expected %b", obs, W_ZERO);
        end
        $display("reset override word=%b", obs);
        reset = 1'b0; Stall = 1'b0; Flush = 1'b0;
    endtask

    task automatic test_exhaustive();
        int         ill_count = 0;
        logic [5:0] op_v;
        logic [9:0] exp_w;
        for (int i = 0; i < 64; i++) begin
            op_v = 6'(i);
            Op = op_v;
            exp_w = expected_word(op_v);
            step();
            checks++;
            if ((^obs) === 1'bx || obs !== exp_w) begin
                errors++;
                $display("FAIL exhaustive_op%b: got %b expected %b", op_v, obs, exp_w);
            end
            if (Illegal === 1'b1) ill_count++;
            $display("exhaustive op=%b word=%b", op_v, obs);
        end
        checks++;
        if (ill_count !== 58) begin
            errors++;
            $display("FAIL illegal_count: got %0d expected 58", ill_count);
        end
    endtask

    initial begin
        reset = 1'b1; Op = 6'b000000; Stall = 1'b0; Flush = 1'b0;
        test_reset();
        test_sweep();
        test_latency();
        test_addi_illegal();
        test_stall();
        test_flush();
        test_reset_override();
        test_exhaustive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
